watch_set_ctrl: RTL



---
 rtl/watch_set_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/watch_set_ctrl.sv
// Time-set controller for the digital watch: freezes the HH:MM:SS counter chain,
// edits a BCD shadow copy field by field, and commits it with a single load pulse.
module watch_set_ctrl #(
   parameter int TIMEOUT_S = 30,
   parameter int HOUR_MAX  = 23
) (
   input  logic        clk_cin,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        key_mode,
   input  logic        key_sel,
   input  logic        key_inc,
   input  logic [23:0] cur_time,
   output logic        run_en,
   output logic [5:0]  load,
   output logic [23:0] preset,
   output logic [5:0]  blink_mask,
   output logic        editing
);

   localparam int            CW       = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
   localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);
   localparam logic [7:0]    HOUR_BCD = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));
   localparam logic [7:0]    MS_BCD   = 8'h59;

   typedef enum logic [2:0] {
      RUN,
      SET_H,
      SET_M,
      SET_S,
      COMMIT
   } state_t;

   state_t        state, state_nxt;
   logic [23:0]   shadow, shadow_nxt;
   logic [CW-1:0] to_cnt, to_cnt_nxt;
   logic          phase, phase_nxt;
   logic          in_edit, nxt_edit, expire, key_any;
   logic          mode_act, sel_act, inc_act;
   logic [5:0]    field_mask;

   // Anything at or above the wrap point (including garbage captured from the
   // counters) returns to 00, so the field always stays valid and in range.
   function automatic logic [7:0] bcd_inc(input logic [7:0] fld, input logic [7:0] max);
      logic [7:0] r;
      if (fld >= max)
         r = 8'h00;
      else if (fld[3:0] >= 4'd9)
         r = {fld[7:4] + 4'd1, 4'd0};
      else
         r = {fld[7:4], fld[3:0] + 4'd1};
      return r;
   endfunction

   always_comb begin
      state_nxt  = state;
      shadow_nxt = shadow;
      to_cnt_nxt = to_cnt;
      phase_nxt  = 1'b0;
      field_mask = 6'b000000;
      key_any    = key_mode | key_sel | key_inc;
      mode_act   = key_mode;
      sel_act    = key_sel & ~key_mode;
      inc_act    = key_inc & ~key_mode & ~key_sel;
      in_edit    = state inside {SET_H, SET_M, SET_S};
      expire     = (TIMEOUT_S != 0) && in_edit && tick_1hz && !key_any && (to_cnt == TO_LAST);

      case (state)
         RUN: begin
            if (mode_act) begin
               shadow_nxt = cur_time;
               state_nxt  = SET_H;
            end
         end
         SET_H, SET_M, SET_S: begin
            if (mode_act)
               state_nxt = COMMIT;
            else if (sel_act)
               state_nxt = (state == SET_H) ? SET_M : (state == SET_M) ? SET_S : SET_H;
            else if (inc_act) begin
               case (state)
                  SET_H:   shadow_nxt[23:16] = bcd_inc(shadow[23:16], HOUR_BCD);
                  SET_M:   shadow_nxt[15:8]  = bcd_inc(shadow[15:8], MS_BCD);
                  default: shadow_nxt[7:0]   = bcd_inc(shadow[7:0], MS_BCD);
               endcase
            end
            else if (expire)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase

      nxt_edit = state_nxt inside {SET_H, SET_M, SET_S};

      // Entering edit, leaving edit and any key press all restart the idle count.
      if (!nxt_edit || !in_edit || key_any)
         to_cnt_nxt = '0;
      else if (tick_1hz)
         to_cnt_nxt = to_cnt + 1'b1;

      if (nxt_edit && in_edit)
         phase_nxt = phase ^ tick_1hz;

      case (state_nxt)
         SET_H:   field_mask = 6'b110000;
         SET_M:   field_mask = 6'b001100;
         SET_S:   field_mask = 6'b000011;
         default: field_mask = 6'b000000;
      endcase
   end

   // Outputs are registered from the next-state view so they line up with state.
   always_ff @(posedge clk_cin) begin
      if (rst) begin
         state      <= RUN;
         shadow     <= '0;
         to_cnt     <= '0;
         phase      <= 1'b0;
         run_en     <= 1'b1;
         load       <= '0;
         preset     <= '0;
         blink_mask <= '0;
         editing    <= 1'b0;
      end
      else begin
         state      <= state_nxt;
         shadow     <= shadow_nxt;
         to_cnt     <= to_cnt_nxt;
         phase      <= phase_nxt;
         run_en     <= (state_nxt == RUN);
         load       <= {6{state_nxt == COMMIT}};
         blink_mask <= phase_nxt ? field_mask : 6'b000000;
         editing    <= nxt_edit;
         if (state_nxt == COMMIT)
            preset <= shadow_nxt;
      end
   end

endmodule
